// File: rtl/sram_io_ctrl_pkg.sv
// Shared definitions for the SRAM / memory-mapped IO controller:
// controller state encoding and default IO register addresses.
package sram_io_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_IO     = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    localparam logic [15:0] SW_ADDR_DEF  = 16'hFFFF;
    localparam logic [15:0] HEX_ADDR_DEF = 16'hFFFE;

    // Wide enough for WAIT_STATES up to 15.
    localparam int CNT_W = 4;

endpackage

// File: rtl/sram_io_ctrl_sram_tristate.sv
// SRAM data pad: drives the shared bus only when enabled and registers
// the bus value on request.
module sram_tristate #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              drive_en,
    input  logic [DATA_W-1:0] wdata,
    input  logic              cap_en,
    output logic [DATA_W-1:0] cap_q,
    inout  wire  [DATA_W-1:0] Data
);

    assign Data = drive_en ? wdata : {DATA_W{1'bz}};

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_q <= '0;
        end else if (cap_en) begin
            cap_q <= Data;
        end
    end

endmodule

// File: rtl/sram_io_ctrl.sv
// CPU-side access controller for an asynchronous SRAM with two
// memory-mapped IO registers (switch input, hex display output).
module sram_io_ctrl
    import sram_io_ctrl_pkg::*;
#(
    parameter int                    DATA_W      = 16,
    parameter int                    CPU_ADDR_W  = 16,
    parameter int                    ADDR_W      = 20,
    parameter int                    WAIT_STATES = 2,
    parameter logic [CPU_ADDR_W-1:0] SW_ADDR     = SW_ADDR_DEF,
    parameter logic [CPU_ADDR_W-1:0] HEX_ADDR    = HEX_ADDR_DEF
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  req,
    input  logic                  we,
    input  logic [1:0]            be,
    input  logic [CPU_ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata,
    output logic                  ready,
    output logic                  busy,
    input  logic [DATA_W-1:0]     Switches,
    output logic [DATA_W-1:0]     hex_val,
    output logic                  CE,
    output logic                  UB,
    output logic                  LB,
    output logic                  OE,
    output logic                  WE,
    output logic [ADDR_W-1:0]     ADDR,
    inout  wire  [DATA_W-1:0]     Data
);

    localparam int HALF = DATA_W / 2;

    state_t                  state;
    state_t                  state_nxt;
    logic [CPU_ADDR_W-1:0]   addr_q;
    logic                    we_q;
    logic [1:0]              be_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [DATA_W-1:0]       io_q;
    logic [DATA_W-1:0]       hex_q;
    logic [DATA_W-1:0]       cap_q;
    logic                    rd_sel_q;
    logic                    drive_en;
    logic                    cap_en;
    logic                    is_io_req;

    assign is_io_req = (addr == SW_ADDR) || (addr == HEX_ADDR) || (be == 2'b00);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        CE        = 1'b1;
        UB        = 1'b1;
        LB        = 1'b1;
        OE        = 1'b1;
        WE        = 1'b1;
        drive_en  = 1'b0;
        cap_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    state_nxt = is_io_req ? ST_IO : ST_SETUP;
                end
            end
            ST_IO: begin
                state_nxt = ST_DONE;
            end
            ST_SETUP: begin
                CE        = 1'b0;
                UB        = ~be_q[1];
                LB        = ~be_q[0];
                OE        = we_q;
                drive_en  = we_q;
                state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                CE       = 1'b0;
                UB       = ~be_q[1];
                LB       = ~be_q[0];
                OE       = we_q;
                WE       = ~we_q;
                drive_en = we_q;
                if (cnt_q == '0) begin
                    cap_en    = ~we_q;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Request fields are frozen at acceptance; ADDR keeps the last one.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            addr_q  <= '0;
            we_q    <= 1'b0;
            be_q    <= 2'b00;
            wdata_q <= '0;
        end else if (state == ST_IDLE && req) begin
            addr_q  <= addr;
            we_q    <= we;
            be_q    <= be;
            wdata_q <= wdata;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q <= '0;
        end else if (state == ST_SETUP) begin
            cnt_q <= CNT_W'(WAIT_STATES);
        end else if (state == ST_ACCESS && cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            io_q     <= '0;
            hex_q    <= '0;
            rd_sel_q <= 1'b0;
        end else begin
            if (state == ST_IO) begin
                if (!we_q) begin
                    if (addr_q == SW_ADDR) begin
                        io_q     <= Switches;
                        rd_sel_q <= 1'b0;
                    end else if (addr_q == HEX_ADDR) begin
                        io_q     <= hex_q;
                        rd_sel_q <= 1'b0;
                    end
                end else if (addr_q == HEX_ADDR) begin
                    if (be_q[1]) begin
                        hex_q[DATA_W-1:HALF] <= wdata_q[DATA_W-1:HALF];
                    end
                    if (be_q[0]) begin
                        hex_q[HALF-1:0] <= wdata_q[HALF-1:0];
                    end
                end
            end
            if (cap_en) begin
                rd_sel_q <= 1'b1;
            end
        end
    end

    // rdata reflects whichever read source completed most recently.
    assign rdata   = rd_sel_q ? cap_q : io_q;
    assign hex_val = hex_q;
    assign ready   = (state == ST_DONE);
    assign busy    = (state != ST_IDLE);
    assign ADDR    = ADDR_W'(addr_q);

    sram_tristate #(
        .DATA_W (DATA_W)
    ) u_pad (
        .clk      (Clk),
        .reset    (Reset),
        .drive_en (drive_en),
        .wdata    (wdata_q),
        .cap_en   (cap_en),
        .cap_q    (cap_q),
        .Data     (Data)
    );

endmodule

// File: tb/tb_sram_io_ctrl.sv
// Directed self-checking bench for sram_io_ctrl with a behavioural SRAM;
// a second instance is built with zero wait states.
module tb_sram_io_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        req0;
    logic        cpu_we;
    logic [1:0]  cpu_be;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] switches;

    logic [15:0] rdata, hex_val;
    logic        ready, busy;
    logic        ce_n, ub_n, lb_n, oe_n, we_n;
    logic [19:0] sram_addr;
    wire  [15:0] data_bus;

    logic [15:0] rdata0, hex_val0;
    logic        ready0, busy0;
    logic        ce0_n, ub0_n, lb0_n, oe0_n, we0_n;
    logic [19:0] sram_addr0;
    wire  [15:0] data_bus0;

    int vectors     = 0;
    int miscompares = 0;

    logic [15:0] mem [0:255];

    always #5 clk = ~clk;

    sram_io_ctrl #(.WAIT_STATES(2)) dut (
        .Clk(clk), .Reset(reset), .req(req), .we(cpu_we), .be(cpu_be),
        .addr(cpu_addr), .wdata(cpu_wdata), .rdata(rdata), .ready(ready),
        .busy(busy), .Switches(switches), .hex_val(hex_val),
        .CE(ce_n), .UB(ub_n), .LB(lb_n), .OE(oe_n), .WE(we_n),
        .ADDR(sram_addr), .Data(data_bus)
    );

    sram_io_ctrl #(.WAIT_STATES(0)) dut0 (
        .Clk(clk), .Reset(reset), .req(req0), .we(cpu_we), .be(cpu_be),
        .addr(cpu_addr), .wdata(cpu_wdata), .rdata(rdata0), .ready(ready0),
        .busy(busy0), .Switches(switches), .hex_val(hex_val0),
        .CE(ce0_n), .UB(ub0_n), .LB(lb0_n), .OE(oe0_n), .WE(we0_n),
        .ADDR(sram_addr0), .Data(data_bus0)
    );

    // Asynchronous SRAM: drives on read strobes, writes enabled lanes on clock.
    assign data_bus  = (!ce_n && !oe_n && we_n) ? mem[sram_addr[7:0]] : 16'hzzzz;
    assign data_bus0 = (!ce0_n && !oe0_n && we0_n) ? 16'h5A5A : 16'hzzzz;

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
            mem[8'h10] <= 16'hBEEF;
            mem[8'h20] <= 16'hAB00;
        end else if (!ce_n && !we_n) begin
            if (!lb_n) mem[sram_addr[7:0]][7:0]  <= data_bus[7:0];
            if (!ub_n) mem[sram_addr[7:0]][15:8] <= data_bus[15:8];
        end
    end

    // Issues one request and records the bus activity over a fixed window.
    task automatic run_access(
        input  logic        w,
        input  logic [1:0]  b,
        input  logic [15:0] a,
        input  logic [15:0] d,
        input  int          req_again,
        output int          lat,
        output int          oe_low,
        output int          oe_setup_low,
        output int          we_low,
        output int          ce_low,
        output int          drv_cnt,
        output int          rdy_cnt,
        output logic [15:0] rd_at_ready,
        output logic        ub0,
        output logic        lb0,
        output logic [19:0] adr0
    );
        @(posedge clk); #1;
        req = 1'b1; cpu_we = w; cpu_be = b; cpu_addr = a; cpu_wdata = d;
        @(posedge clk); #1;
        req = 1'b0;
        lat = -1; oe_low = 0; oe_setup_low = 0; we_low = 0; ce_low = 0;
        drv_cnt = 0; rdy_cnt = 0; rd_at_ready = 16'h0000;
        ub0 = 1'b1; lb0 = 1'b1; adr0 = '0;
        for (int j = 0; j < 12; j++) begin
            if (j == req_again) req = 1'b1;
            else if (j == req_again + 1) req = 1'b0;
            if (j == 0) begin
                ub0 = ub_n; lb0 = lb_n; adr0 = sram_addr;
                if (!oe_n) oe_setup_low = 1;
            end
            if (ready) begin
                rdy_cnt++;
                if (lat < 0) begin
                    lat = j + 1;
                    rd_at_ready = rdata;
                end
            end
            if (!oe_n) oe_low++;
            if (!we_n) we_low++;
            if (!ce_n) ce_low++;
            if (w && data_bus === d) drv_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 1'b0; req0 = 1'b0; cpu_we = 1'b0; cpu_be = 2'b00;
        cpu_addr = 16'h0000; cpu_wdata = 16'h0000; switches = 16'h0000;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        vectors++;
        if ({busy, ready} !== 2'b00) begin
            miscompares++; $display("FAIL reset_busy_ready: got %b expected 00", {busy, ready});
        end
        vectors++;
        if ({ce_n, ub_n, lb_n, oe_n, we_n} !== 5'b11111) begin
            miscompares++; $display("FAIL reset_strobes: got %b expected 11111", {ce_n, ub_n, lb_n, oe_n, we_n});
        end
        vectors++;
        if (rdata !== 16'h0000 || hex_val !== 16'h0000 || sram_addr !== 20'h00000) begin
            miscompares++; $display("FAIL reset_regs: got rdata=%h hex=%h addr=%h expected all zero", rdata, hex_val, sram_addr);
        end
    endtask

    task automatic test_sram_read();
        int lat, oe_low, oe_s, we_low, ce_low, drv, rdy;
        logic [15:0] rd; logic ub0, lb0; logic [19:0] a0;
        run_access(1'b0, 2'b11, 16'h0010, 16'h0000, -5,
                   lat, oe_low, oe_s, we_low, ce_low, drv, rdy, rd, ub0, lb0, a0);
        vectors++;
        if (lat !== 5) begin
            miscompares++; $display("FAIL read_latency: got %0d expected 5", lat);
        end
        vectors++;
        if (rd !== 16'hBEEF || rdata !== 16'hBEEF) begin
            miscompares++; $display("FAIL read_data: got %h/%h expected beef", rd, rdata);
        end
        vectors++;
        if (oe_s !== 1 || oe_low - oe_s !== 3) begin
            miscompares++; $display("FAIL read_oe: got setup=%0d access=%0d expected 1 and 3", oe_s, oe_low - oe_s);
        end
        vectors++;
        if (we_low !== 0 || rdy !== 1) begin
            miscompares++; $display("FAIL read_we_ready: got we_low=%0d ready=%0d expected 0 and 1", we_low, rdy);
        end
        vectors++;
        if (a0 !== 20'h00010 || {ub0, lb0} !== 2'b00 || ce_low !== 4) begin
            miscompares++; $display("FAIL read_addr_lanes: got addr=%h ublb=%b ce_low=%0d expected 00010 00 4", a0, {ub0, lb0}, ce_low);
        end
    endtask

    task automatic test_sram_write();
        int lat, oe_low, oe_s, we_low, ce_low, drv, rdy;
        logic [15:0] rd; logic ub0, lb0; logic [19:0] a0;
        run_access(1'b1, 2'b01, 16'h0020, 16'h1234, -5,
                   lat, oe_low, oe_s, we_low, ce_low, drv, rdy, rd, ub0, lb0, a0);
        vectors++;
        if ({ub0, lb0} !== 2'b10) begin
            miscompares++; $display("FAIL write_lanes: got ub,lb=%b expected 10", {ub0, lb0});
        end
        vectors++;
        if (we_low !== 3 || oe_low !== 0) begin
            miscompares++; $display("FAIL write_strobes: got we_low=%0d oe_low=%0d expected 3 and 0", we_low, oe_low);
        end
        vectors++;
        if (drv !== 4) begin
            miscompares++; $display("FAIL write_drive_cycles: got %0d expected 4", drv);
        end
        vectors++;
        if (lat !== 5 || rdy !== 1) begin
            miscompares++; $display("FAIL write_ready: got lat=%0d pulses=%0d expected 5 and 1", lat, rdy);
        end
        run_access(1'b0, 2'b11, 16'h0020, 16'h0000, -5,
                   lat, oe_low, oe_s, we_low, ce_low, drv, rdy, rd, ub0, lb0, a0);
        vectors++;
        if (rd !== 16'hAB34) begin
            miscompares++; $display("FAIL write_readback: got %h expected ab34", rd);
        end
    endtask

    task automatic test_io();
        int lat, oe_low, oe_s, we_low, ce_low, drv, rdy;
        logic [15:0] rd; logic ub0, lb0; logic [19:0] a0;
        switches = 16'h00A5;
        run_access(1'b0, 2'b11, 16'hFFFF, 16'h0000, -5,
                   lat, oe_low, oe_s, we_low, ce_low, drv, rdy, rd, ub0, lb0, a0);
        vectors++;
        if (lat !== 2 || rd !== 16'h00A5) begin
            miscompares++; $display("FAIL io_switch_read: got lat=%0d rdata=%h expected 2 00a5", lat, rd);
        end
        vectors++;
        if (ce_low !== 0) begin
            miscompares++; $display("FAIL io_ce: got %0d low cycles expected 0", ce_low);
        end
        run_access(1'b1, 2'b10, 16'hFFFE, 16'hC0DE, -5,
                   lat, oe_low, oe_s, we_low, ce_low, drv, rdy, rd, ub0, lb0, a0);
        vectors++;
        if (hex_val !== 16'hC000) begin
            miscompares++; $display("FAIL io_hex_upper: got %h expected c000", hex_val);
        end
        run_access(1'b1, 2'b01, 16'hFFFE, 16'h0012, -5,
                   lat, oe_low, oe_s, we_low, ce_low, drv, rdy, rd, ub0, lb0, a0);
        vectors++;
        if (hex_val !== 16'hC012 || ce_low !== 0) begin
            miscompares++; $display("FAIL io_hex_lower: got %h ce_low=%0d expected c012 0", hex_val, ce_low);
        end
        run_access(1'b0, 2'b11, 16'hFFFE, 16'h0000, -5,
                   lat, oe_low, oe_s, we_low, ce_low, drv, rdy, rd, ub0, lb0, a0);
        vectors++;
        if (rd !== 16'hC012) begin
            miscompares++; $display("FAIL io_hex_read: got %h expected c012", rd);
        end
    endtask

    task automatic test_back_to_back();
        int lat, oe_low, oe_s, we_low, ce_low, drv, rdy;
        logic [15:0] rd; logic ub0, lb0; logic [19:0] a0;
        run_access(1'b0, 2'b11, 16'h0010, 16'h0000, 1,
                   lat, oe_low, oe_s, we_low, ce_low, drv, rdy, rd, ub0, lb0, a0);
        vectors++;
        if (rdy !== 1 || lat !== 5) begin
            miscompares++; $display("FAIL busy_ignore: got pulses=%0d lat=%0d expected 1 and 5", rdy, lat);
        end
        vectors++;
        if (busy !== 1'b0 || ce_low !== 4) begin
            miscompares++; $display("FAIL busy_ignore_idle: got busy=%b ce_low=%0d expected 0 and 4", busy, ce_low);
        end
    endtask

    task automatic test_reset_mid_access();
        int rdy;
        @(posedge clk); #1;
        req = 1'b1; cpu_we = 1'b1; cpu_be = 2'b11; cpu_addr = 16'h0030; cpu_wdata = 16'h5555;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (we_n !== 1'b0) begin
            miscompares++; $display("FAIL abort_in_access: got WE=%b expected 0", we_n);
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        vectors++;
        if ({we_n, ce_n, busy, ready} !== 4'b1100) begin
            miscompares++; $display("FAIL abort_strobes: got we,ce,busy,ready=%b expected 1100", {we_n, ce_n, busy, ready});
        end
        vectors++;
        if (data_bus === 16'h5555) begin
            miscompares++; $display("FAIL abort_bus: got %h expected released bus", data_bus);
        end
        vectors++;
        if (rdata !== 16'h0000 || hex_val !== 16'h0000 || sram_addr !== 20'h00000) begin
            miscompares++; $display("FAIL abort_regs: got rdata=%h hex=%h addr=%h expected zeros", rdata, hex_val, sram_addr);
        end
        rdy = 0;
        for (int j = 0; j < 6; j++) begin
            if (ready || busy) rdy++;
            @(posedge clk); #1;
        end
        vectors++;
        if (rdy !== 0) begin
            miscompares++; $display("FAIL abort_no_ready: got %0d active cycles expected 0", rdy);
        end
    endtask

    task automatic test_ws0_read();
        int lat;
        logic [15:0] rd;
        @(posedge clk); #1;
        req0 = 1'b1; cpu_we = 1'b0; cpu_be = 2'b11; cpu_addr = 16'h0040;
        @(posedge clk); #1;
        req0 = 1'b0;
        lat = -1; rd = 16'h0000;
        for (int j = 0; j < 8; j++) begin
            if (ready0 && lat < 0) begin
                lat = j + 1;
                rd = rdata0;
            end
            @(posedge clk); #1;
        end
        vectors++;
        if (lat !== 3 || rd !== 16'h5A5A) begin
            miscompares++; $display("FAIL ws0_read: got lat=%0d rdata=%h expected 3 5a5a", lat, rd);
        end
    endtask

    initial begin
        test_reset();
        test_sram_read();
        test_sram_write();
        test_io();
        test_back_to_back();
        test_reset_mid_access();
        test_ws0_read();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
